fxp_mult_pipe: RTL and testbench

Pipelined, parametrised signed fixed-point multiplier with valid/ready flow control, selectable rounding and overflow detection. It is the next generation of the team's combinational Q8.8 multiply and serves the same role in the noise-cancelling datapath: filter-tap and gain products. It adds configurable width, fraction point and pipeline depth, and it can be back-pressured so it can sit between buffered stages.

---
 rtl/fxp_mult_pipe.sv | 129 ++++++++++++
 tb/tb_fxp_mult_pipe.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_mult_pipe.sv
// rtl/fxp_mult_pipe.sv - pipelined signed fixed-point multiplier with valid/ready flow control
// Optional build macro: FXP_MULT_SAT_EN (saturate out1 on overflow instead of wrapping)
module fxp_mult_pipe #(
   parameter int DW     = 16,
   parameter int FRAC   = 8,
   parameter int STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in1,
   input  logic [DW-1:0] in2,
   input  logic          rnd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out1,
   output logic          ovf,
   output logic          ovf_sticky,
   input  logic          clr_sticky
);

   // Product width with one guard bit so the rounding add can never wrap.
   localparam int PW = 2*DW + 1;
   // Bits that must all equal the sign bit for the shifted result to fit in DW.
   localparam int HW = PW - DW + 1;
   localparam logic signed [PW-1:0] HALF =
      (FRAC > 0) ? (PW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;

   logic signed [PW-1:0] a_x;
   logic signed [PW-1:0] b_x;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] prod_r;
   logic signed [PW-1:0] shifted;
   logic [HW-1:0]        hi;
   logic [DW-1:0]        res;
   logic                 res_ovf;

   logic [STAGES-1:0]    vld;
   logic [STAGES-1:0]    load;
   logic [STAGES-1:0]    nv;
   logic [STAGES-1:0]    ovs;
   logic [STAGES-1:0]    no;
   logic [DW-1:0]        dat [STAGES];
   logic [DW-1:0]        nd  [STAGES];
   logic                 acc;

   // Multiply, optionally round half-up, shift to the result point and detect overflow.
   always_comb begin
      a_x     = {{(PW-DW){in1[DW-1]}}, in1};
      b_x     = {{(PW-DW){in2[DW-1]}}, in2};
      prod    = a_x * b_x;
      prod_r  = prod + (rnd ? HALF : '0);
      shifted = prod_r >>> FRAC;
      hi      = shifted[PW-1:DW-1];
      res_ovf = ~((&hi) | ~(|hi));
      res     = shifted[DW-1:0];
`ifdef FXP_MULT_SAT_EN
      if (res_ovf) begin
         res = shifted[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
`endif
   end

   // A stage loads when it or any later stage is empty, or the consumer accepts.
   always_comb begin
      acc  = out_ready;
      load = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         acc     = acc | ~vld[k];
         load[k] = acc;
      end
   end

   // Per-stage incoming valid/data/overflow: stage 0 takes the new pair, others the previous stage.
   always_comb begin
      nv[0] = in_valid;
      nd[0] = res;
      no[0] = res_ovf;
      for (int k = 1; k < STAGES; k++) begin
         nv[k] = vld[k-1];
         nd[k] = dat[k-1];
         no[k] = ovs[k-1];
      end
   end

   // Stage valid bits advance whenever their stage loads; bubbles are filled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) vld[k] <= nv[k];
         end
      end
   end

   // Data registers only capture real results, so they stay quiet on bubbles and stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) dat[k] <= '0;
         ovs <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k] && nv[k]) begin
               dat[k] <= nd[k];
               ovs[k] <= no[k];
            end
         end
      end
   end

   // Sticky overflow: a transferring overflowed result wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && ovf) begin
         ovf_sticky <= 1'b1;
      end else if (clr_sticky) begin
         ovf_sticky <= 1'b0;
      end
   end

   assign in_ready  = load[0];
   assign out_valid = vld[STAGES-1];
   assign out1      = dat[STAGES-1];
   assign ovf       = ovs[STAGES-1];

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb/tb_fxp_mult_pipe.sv - self-checking bench for fxp_mult_pipe with arithmetic reference model
module tb_fxp_mult_pipe;

`ifdef FXP_MULT_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct {
      logic [63:0] res;
      bit          o;
   } exp_t;

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default-parameter DUT
   logic        in_valid = 0, in_ready, rnd = 0, out_valid, out_ready = 0, ovf, ovf_sticky, clr_sticky = 0;
   logic [15:0] in1 = 0, in2 = 0, out1;

   // sweep DUT A: DW=24, FRAC=12, STAGES=4
   logic        v24 = 0, rdy24, r24 = 0, ov24, val24, st24;
   logic [23:0] a24 = 0, b24 = 0, o24;
   // sweep DUT B: DW=8, FRAC=0, STAGES=1
   logic        v8 = 0, rdy8, r8 = 0, ov8, val8, st8;
   logic [7:0]  a8 = 0, b8 = 0, o8;
   logic        one = 1'b1, zero = 1'b0;

   fxp_mult_pipe #(.DW(16), .FRAC(8), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
      .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .out1(out1), .ovf(ovf),
      .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky));

   fxp_mult_pipe #(.DW(24), .FRAC(12), .STAGES(4)) u_dut24 (
      .clk(clk), .rst(rst), .in_valid(v24), .in_ready(rdy24), .in1(a24), .in2(b24),
      .rnd(r24), .out_valid(val24), .out_ready(one), .out1(o24), .ovf(ov24),
      .ovf_sticky(st24), .clr_sticky(zero));

   fxp_mult_pipe #(.DW(8), .FRAC(0), .STAGES(1)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in1(a8), .in2(b8),
      .rnd(r8), .out_valid(val8), .out_ready(one), .out1(o8), .ovf(ov8),
      .ovf_sticky(st8), .clr_sticky(zero));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: exact integer product, optional half-LSB add, arithmetic shift, range test.
   function automatic void model(input int dw, input int frac, input logic [63:0] a,
                                 input logic [63:0] b, input bit r,
                                 output logic [63:0] res, output bit o);
      longint sa, sb, p, s, mx, mn, mask;
      sa   = longint'(a << (64 - dw)) >>> (64 - dw);
      sb   = longint'(b << (64 - dw)) >>> (64 - dw);
      p    = sa * sb;
      if (r && frac > 0) p = p + (longint'(1) <<< (frac - 1));
      s    = p >>> frac;
      mx   = (longint'(1) <<< (dw - 1)) - 1;
      mn   = -(longint'(1) <<< (dw - 1));
      mask = (longint'(1) <<< dw) - 1;
      o    = (s > mx) || (s < mn);
      if (o && SAT) s = (s < 0) ? mn : mx;
      res  = 64'(s & mask);
   endfunction

   exp_t q16[$], q24[$], q8[$];
   bit          stall = 0;
   logic [15:0] prev_out;
   logic        prev_ovf;

   // Compare process: scoreboards for all three DUTs, stall stability and in_ready rule.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q16.delete(); q24.delete(); q8.delete();
         stall = 0;
      end else begin
         check("in_ready_rule", in_ready, !(q16.size() == 2 && !out_ready));
         if (stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_out1", out1, prev_out);
            check("hold_ovf", ovf, prev_ovf);
         end
         if (out_valid) begin
            if (q16.size() == 0) check("spurious_out", out_valid, 0);
            else begin
               check("out1", out1, q16[0].res);
               check("ovf", ovf, q16[0].o);
               if (out_ready) void'(q16.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            model(16, 8, 64'(in1), 64'(in2), rnd, e.res, e.o);
            q16.push_back(e);
         end
         stall    = out_valid && !out_ready;
         prev_out = out1;
         prev_ovf = ovf;

         check("in_ready24", rdy24, 1);
         if (val24) begin
            if (q24.size() == 0) check("spurious24", val24, 0);
            else begin
               check("out24", o24, q24[0].res);
               check("ovf24", ov24, q24[0].o);
               void'(q24.pop_front());
            end
         end
         if (v24) begin
            model(24, 12, 64'(a24), 64'(b24), r24, e.res, e.o);
            q24.push_back(e);
         end

         check("in_ready8", rdy8, 1);
         if (val8) begin
            if (q8.size() == 0) check("spurious8", val8, 0);
            else begin
               check("out8", o8, q8[0].res);
               check("ovf8", ov8, q8[0].o);
               void'(q8.pop_front());
            end
         end
         if (v8) begin
            model(8, 0, 64'(a8), 64'(b8), r8, e.res, e.o);
            q8.push_back(e);
         end
      end
   end

   // Single pair through an empty pipe with out_ready=1; checks latency and literal result.
   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic r,
                           input logic [15:0] exp_res, input logic exp_o, input string nm);
      int n;
      @(posedge clk); #1;
      in1 = a; in2 = b; rnd = r; in_valid = 1; out_ready = 1;
      @(posedge clk); #1;
      in_valid = 0;
      n = 1;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({nm, "_latency"}, n, 2);
      check({nm, "_out1"}, out1, exp_res);
      check({nm, "_ovf"}, ovf, exp_o);
   endtask

   task automatic pin_model(input int dw, input int frac, input logic [63:0] a, input logic [63:0] b,
                            input bit r, input logic [63:0] exp_res, input bit exp_o, input string nm);
      logic [63:0] res;
      bit          o;
      model(dw, frac, a, b, r, res, o);
      check({nm, "_model_res"}, res, exp_res);
      check({nm, "_model_ovf"}, o, exp_o);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
   end

   initial begin
      logic [23:0] c24 [5];
      logic [7:0]  c8  [5];
      int          guard;
      bit          done;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out1", out1, 0);
      check("rst_ovf", ovf, 0);
      check("rst_sticky", ovf_sticky, 0);
      @(negedge clk);
      rst = 0;
      #1;
      check("in_ready_after_rst", in_ready, 1);

      // hand-computed values that pin the model
      pin_model(16, 8, 64'h0180, 64'h0200, 0, 64'h0300, 0, "basic");
      pin_model(16, 8, 64'h0001, 64'h0080, 1, 64'h0001, 0, "rnd_up");
      pin_model(16, 8, 64'hFFFF, 64'h0080, 0, 64'hFFFF, 0, "neg_trunc");
      pin_model(16, 8, 64'h7F00, 64'h0200, 0, SAT ? 64'h7FFF : 64'hFE00, 1, "ovf_pos");
      pin_model(8, 0, 64'h80, 64'h80, 0, SAT ? 64'h7F : 64'h00, 1, "ovf8");

      // basic, rounding, overflow
      send_one(16'h0180, 16'h0200, 0, 16'h0300, 0, "basic");
      send_one(16'hFF00, 16'h0100, 0, 16'hFF00, 0, "neg_one");
      send_one(16'h0001, 16'h0080, 0, 16'h0000, 0, "half_trunc");
      send_one(16'h0001, 16'h0080, 1, 16'h0001, 0, "half_round");
      send_one(16'hFFFF, 16'h0080, 0, 16'hFFFF, 0, "nhalf_trunc");
      send_one(16'hFFFF, 16'h0080, 1, 16'h0000, 0, "nhalf_round");
      check("sticky_before_ovf", ovf_sticky, 0);
      send_one(16'h7F00, 16'h0200, 0, SAT ? 16'h7FFF : 16'hFE00, 1, "ovf_pos");
      send_one(16'h8000, 16'h8000, 0, SAT ? 16'h7FFF : 16'h0000, 1, "ovf_min");
      @(posedge clk); #1;
      check("sticky_set", ovf_sticky, 1);
      clr_sticky = 1;
      @(posedge clk); #1;
      clr_sticky = 0;
      check("sticky_clear", ovf_sticky, 0);

      // overflowed result parked at the output, then transferred together with a clear
      out_ready = 0;
      in1 = 16'h8000; in2 = 16'h8000; rnd = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      #1;
      check("parked_valid", out_valid, 1);
      check("sticky_not_yet", ovf_sticky, 0);
      out_ready = 1; clr_sticky = 1;
      @(posedge clk); #1;
      clr_sticky = 0;
      check("sticky_set_wins", ovf_sticky, 1);

      // back-pressure stream
      for (int i = 0; i < 8; i++) begin
         in1 = 16'($urandom); in2 = 16'($urandom); rnd = 1'($urandom); in_valid = 1;
         done = 0; guard = 0;
         while (!done && guard < 100) begin
            out_ready = 1'($urandom);
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
            guard++;
         end
         if (!done) check("stream_xfer", 0, 1);
      end
      in_valid = 0; out_ready = 1;
      guard = 0;
      while (q16.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("stream_drained", q16.size(), 0);

      // reset with two results in flight
      out_ready = 0;
      in1 = 16'h0300; in2 = 16'h0200; rnd = 0; in_valid = 1;
      @(posedge clk); #1;
      in1 = 16'h0100; in2 = 16'h0500;
      @(posedge clk); #1;
      in_valid = 0;
      check("inflight_valid", out_valid, 1);
      #2;
      rst = 1;
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_out1", out1, 0);
      @(posedge clk); #3;
      rst = 0;
      out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("no_stale_after_rst", out_valid, 0);
      end

      // parameter sweep: corner pairs then random vectors
      c24[0] = 24'h000000; c24[1] = 24'h000001; c24[2] = 24'hFFFFFF; c24[3] = 24'h7FFFFF; c24[4] = 24'h800000;
      c8[0]  = 8'h00;      c8[1]  = 8'h01;      c8[2]  = 8'hFF;      c8[3]  = 8'h7F;      c8[4]  = 8'h80;
      @(posedge clk); #1;
      v24 = 1; v8 = 1;
      for (int i = 0; i < 25; i++) begin
         a24 = c24[i / 5]; b24 = c24[i % 5]; r24 = 1'(i);
         a8  = c8[i / 5];  b8  = c8[i % 5];  r8  = 1'(i);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 1000; i++) begin
         a24 = 24'($urandom); b24 = 24'($urandom); r24 = 1'($urandom);
         a8  = 8'($urandom);  b8  = 8'($urandom);  r8  = 1'($urandom);
         @(posedge clk); #1;
      end
      v24 = 0; v8 = 0;
      repeat (8) @(posedge clk);
      #1;
      check("sweep24_drained", q24.size(), 0);
      check("sweep8_drained", q8.size(), 0);
      check("final_drained", q16.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
